// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan logic.
package seg_pkg;

    localparam logic [6:0] SEG_OFF    = 7'b1111111;
    localparam logic [3:0] AN_OFF     = 4'b1111;
    localparam int         NUM_DIGITS = 4;

    // Defaults for a 50 MHz crystal: 1 kHz per digit, 10 us blank gap.
    localparam int SCAN_DIV_50M  = 50000;
    localparam int BLANK_CYC_50M = 500;

    typedef enum logic {
        PH_BLANK,
        PH_DRIVE
    } phase_e;

endpackage

// File: rtl/hex2_7seg_lut.sv
// Hex nibble to active-low seven-segment pattern, seg[0]=a .. seg[6]=g.
module hex2_7seg_lut (
    input  logic [3:0] hex_i,
    output logic [0:6] seg_o
);

    always_comb begin
        case (hex_i)
            4'h0: seg_o = 7'b0000001;
            4'h1: seg_o = 7'b1001111;
            4'h2: seg_o = 7'b0010010;
            4'h3: seg_o = 7'b0000110;
            4'h4: seg_o = 7'b1001100;
            4'h5: seg_o = 7'b0100100;
            4'h6: seg_o = 7'b0100000;
            4'h7: seg_o = 7'b0001111;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0000100;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b1100000;
            4'hC: seg_o = 7'b0110001;
            4'hD: seg_o = 7'b1000010;
            4'hE: seg_o = 7'b0110000;
            default: seg_o = 7'b0111000;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Round-robin scan of four seven-segment digits with a blank gap before each
// slot and a once-per-frame shadow of the display data.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = SCAN_DIV_50M,
    parameter int BLANK_CYC = BLANK_CYC_50M,
    parameter int CW        = 17
) (
    input  logic        CLK1,
    input  logic        arst,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  dig_en,
    output logic [0:6]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_tick
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   sh_val_q, sh_val_d;
    logic [3:0]    sh_dp_q, sh_dp_d;
    logic [3:0]    sh_en_q, sh_en_d;
    logic [3:0]    an_q, an_d;
    logic [0:6]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          tick_q, tick_d;

    logic          slot_end;
    logic          capture;
    phase_e        phase;
    logic [3:0]    nibble;
    logic [0:6]    lut_seg;

    assign slot_end = (cnt_q == CW'(SCAN_DIV - 1));
    assign capture  = (idx_q == 2'd0) && (cnt_q == '0);
    assign phase    = (cnt_q < CW'(BLANK_CYC)) ? PH_BLANK : PH_DRIVE;
    assign nibble   = sh_val_q[{idx_q, 2'b00} +: 4];

    hex2_7seg_lut u_lut (
        .hex_i (nibble),
        .seg_o (lut_seg)
    );

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        idx_d    = slot_end ? idx_q + 2'd1 : idx_q;
        sh_val_d = sh_val_q;
        sh_dp_d  = sh_dp_q;
        sh_en_d  = sh_en_q;
        an_d     = AN_OFF;
        seg_d    = SEG_OFF;
        dp_d     = 1'b1;
        tick_d   = slot_end && (idx_q == 2'd3);

        // Capturing only at the start of digit 0 keeps a frame from tearing.
        if (capture) begin
            sh_val_d = value;
            sh_dp_d  = dp_in;
            sh_en_d  = dig_en;
        end

        if (phase == PH_DRIVE && sh_en_q[idx_q]) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = lut_seg;
            dp_d  = ~sh_dp_q[idx_q];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK1 or posedge arst) begin
        if (arst) begin
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            sh_val_q <= '0;
            sh_dp_q  <= '0;
            sh_en_q  <= '0;
            an_q     <= AN_OFF;
            seg_q    <= SEG_OFF;
            dp_q     <= 1'b1;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            sh_val_q <= sh_val_d;
            sh_dp_q  <= sh_dp_d;
            sh_en_q  <= sh_en_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            tick_q   <= tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = tick_q;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplex scheduler for the shared 4-digit seven-segment bus. It gives each of four digit slots a fixed share of the common segment lines in round-robin order, driving one anode at a time. A blanking gap precedes every slot to suppress ghosting. Display data is shadowed once per frame so a value that changes mid-frame never tears. It replaces the all-anodes-on scheme in the top level and sits between the hex counters and the board pins.

Parameters:
SCAN_DIV, 50000, clock cycles per digit slot (1 kHz per digit at 50 MHz); must be >= 2.
BLANK_CYC, 500, cycles at the start of each slot with all anodes off; 0 <= BLANK_CYC < SCAN_DIV.
CW, 17, slot counter width; must satisfy 2^CW > SCAN_DIV-1.

Ports:
CLK1  in  1  system clock, single clock domain.
arst  in  1  asynchronous reset, active-high.
value  in  16  four hex digits; digit i = value[4i+3:4i].
dp_in  in  4  decimal point request per digit, 1 = lit.
dig_en  in  4  digit enable mask, 1 = digit shown.
seg  out  [0:6]  segment lines, active-low (hex2_7seg_lut encoding).
dp  out  1  decimal point line, active-low.
an  out  4  anodes, active-low; an[i] selects digit i.
frame_tick  out  1  one-cycle pulse at the end of digit 3's slot.

Behaviour:
- Clock and reset: one clock, CLK1. Reset arst is asynchronous and active-high.
- Reset value of every output: an=4'b1111, seg=7'b1111111, dp=1, frame_tick=0.
- Reset value of internal state: cnt=0, idx=0, shadow value/dp/en = 0.
- Reset mid-operation: outputs go to their reset values immediately, without waiting for a clock edge.
- Edge numbering: edge 1 is the first rising CLK1 edge after arst falls.
- Slot counter cnt: counts 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and idx advances (idx = idx+1 mod 4, so 3 wraps to 0).
- Phase: BLANK when cnt < BLANK_CYC, otherwise DRIVE.
- Shadow capture: value, dp_in and dig_en load into shadow registers on any edge where the pre-edge state is idx=0, cnt=0. Edge 1 is always a load. Inputs are ignored at all other times.
- Registered outputs: an, seg, dp and frame_tick are registered, with one cycle of latency. Each is computed from the pre-edge cnt, idx and shadow.
- Output timing: after edge e, the pre-edge cnt is (e-1) mod SCAN_DIV.
- DRIVE with the shadow enable bit set for idx:
  - an = ~(1<<idx)
  - seg = LUT(shadow digit idx)
  - dp = ~shadow_dp[idx]
- BLANK, or a disabled digit: an=1111, seg=1111111, dp=1.
- frame_tick is 1 after an edge whose pre-edge state is idx=3, cnt=SCAN_DIV-1; 0 otherwise.
- BLANK_CYC=0: there is no blank gap, so some anode is low continuously from edge 2 onward when all digits are enabled.
- Simultaneous events: a capture coincides with the slot 0 start, so new data appears first in digit 0's DRIVE of the new frame.

Decomposition:
- Shared package (seg_pkg):
  - SEG_OFF = 7'b1111111
  - AN_OFF = 4'b1111
  - NUM_DIGITS = 4
  - default SCAN_DIV and BLANK_CYC for a 50 MHz crystal
- Sub-module: the existing hex2_7seg_lut, instantiated once on the muxed shadow nibble.
- Slot counting: a local counter inside seg_scan_ctrl, not the shared counter module, because the wrap point is not a power of two.

Test Plan:
All scenarios use SCAN_DIV=8, BLANK_CYC=2 unless noted.
1. Reset mid-operation: assert arst while an=1110 -> an=1111, seg=1111111, dp=1, frame_tick=0 before the next CLK1 edge.
2. Normal scan: value=16'h1234, dig_en=1111, release reset.
   - After edges 3..8: an=1110, seg=LUT(4).
   - After edges 11..16: an=1101, seg=LUT(3).
   - After edges 19..24: an=1011, seg=LUT(2).
   - After edges 27..32: an=0111, seg=LUT(1).
   - Blank edges 1..2, 9..10, etc.: an=1111.
   - frame_tick=1 only in the cycle after edge 32.
3. Tearing: change value to 16'hABCD at edge 12.
   - Digits 1-3 of frame 1 still show 3, 2, 1.
   - Capture at edge 33.
   - After edges 35..40: an=1110, seg=LUT(D).
4. Enable mask: dig_en=0101 -> an[1] and an[3] stay 1 for a full frame; digits 0 and 2 scan normally.
5. Decimal point: dp_in=0010 -> dp=0 only during digit 1 DRIVE (after edges 11..16); dp=1 everywhere else.
6. No blanking: BLANK_CYC=0, dig_en=1111 -> an never equals 1111 after edge 2; exactly one an bit is low in every cycle.
